// File: rtl/qea_host_sequencer.sv
// Host-side run sequencer for one QEA pass: ctx load, |0..0> init, start, count, readback.
// Latency: ctx writes combinational per beat; init 1 word/cycle; readback 2+READ_LAT cycles/word + stall.
// Backpressure: ctx stream paced by i_ctx_valid; readback holds o_rd_valid/o_rd_data until i_rd_ready. Optional QEA_SEQ_TIMEOUT_EN.
module qea_host_sequencer #(
    parameter int PE_NUM_WIDTH            = 2,
    parameter int PE_NUM                  = 4,
    parameter int DATA_WIDTH              = 32,
    parameter int STATE_DATA_WIDTH        = DATA_WIDTH * 2,
    parameter int STATE_ADDR_WIDTH        = 16,
    parameter int GATE_CONTEXT_DATA_WIDTH = DATA_WIDTH * 2,
    parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH          = 6,
    parameter int NUM_FRAC_BIT            = 30,
    parameter int READ_LAT                = 1,
    parameter int CNT_WIDTH               = 32
`ifdef QEA_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC             = 2**20
`endif
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 i_cmd_start,
    input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
    input  logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   i_ins_num,
    input  logic                                 i_ctx_valid,
    output logic                                 o_ctx_ready,
    input  logic [GATE_CONTEXT_DATA_WIDTH-1:0]   i_ctx_data,
    output logic                                 o_qea_start,
    output logic [MAX_QBIT_WIDTH-1:0]            o_qbit_num,
    output logic                                 o_ctx_en,
    output logic                                 o_ctx_wea,
    output logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   o_ctx_addr,
    output logic [GATE_CONTEXT_DATA_WIDTH-1:0]   o_ctx_data,
    output logic [PE_NUM-1:0]                    o_state_ena,
    output logic [PE_NUM-1:0]                    o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
    input  logic                                 i_qea_complete,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout,
    output logic                                 o_rd_valid,
    input  logic                                 i_rd_ready,
    output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_rd_data,
    output logic                                 o_busy,
    output logic                                 o_done,
    output logic                                 o_err,
    output logic [CNT_WIDTH-1:0]                 o_cycles
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_CTX    = 4'd1;
    localparam logic [3:0] S_INIT   = 4'd2;
    localparam logic [3:0] S_START  = 4'd3;
    localparam logic [3:0] S_RUN    = 4'd4;
    localparam logic [3:0] S_RISSUE = 4'd5;
    localparam logic [3:0] S_RWAIT  = 4'd6;
    localparam logic [3:0] S_ROUT   = 4'd7;
    localparam logic [3:0] S_DONE   = 4'd8;

    localparam int WORD_W = PE_NUM * STATE_DATA_WIDTH;

    localparam logic [GATE_CONTEXT_ADDR_WIDTH-1:0] CTX_ONE  = 1;
    localparam logic [STATE_ADDR_WIDTH-1:0]        ADDR_ONE = 1;
    localparam logic [CNT_WIDTH-1:0]               CNT_ONE  = 1;
    localparam logic [2:0]                         LAT_ONE  = 3'd1;
    localparam logic [2:0]                         LAT_LAST = 3'(READ_LAT - 1);
    localparam logic [STATE_ADDR_WIDTH:0]          DEPTH_ONE = 1;

    // Amplitude 1.0 + 0i sits in the most significant PE slot of word 0.
    localparam logic [DATA_WIDTH-1:0]       ONE_RE  = DATA_WIDTH'(64'd1 << NUM_FRAC_BIT);
    localparam logic [STATE_DATA_WIDTH-1:0] ONE_AMP = STATE_DATA_WIDTH'({ONE_RE, {DATA_WIDTH{1'b0}}});
    localparam logic [WORD_W-1:0]           INIT_WORD =
        {ONE_AMP, {((PE_NUM - 1) * STATE_DATA_WIDTH){1'b0}}};

`ifdef QEA_SEQ_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);
`endif

    logic [3:0]                           state_q, state_d;
    logic [MAX_QBIT_WIDTH-1:0]            qbit_q, qbit_d;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ins_q, ins_d;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0]   ctx_k_q, ctx_k_d;
    logic [STATE_ADDR_WIDTH-1:0]          last_q, last_d;
    logic [STATE_ADDR_WIDTH-1:0]          addr_q, addr_d;
    logic [2:0]                           lat_q, lat_d;
    logic [CNT_WIDTH-1:0]                 cycles_q, cycles_d;
    logic [WORD_W-1:0]                    rd_dat_q, rd_dat_d;
    logic                                 err_q, err_d;
`ifdef QEA_SEQ_TIMEOUT_EN
    logic [31:0]                          tmo_q, tmo_d;
`endif

    logic [31:0]                 qbit_ext;
    logic [31:0]                 addr_bits;
    logic                        cmd_bad;
    logic [STATE_ADDR_WIDTH:0]   depth_full;
    logic [STATE_ADDR_WIDTH-1:0] depth_last;
    logic [GATE_CONTEXT_ADDR_WIDTH-1:0] ins_last;

    // Word count is 2**(qbit-PE_NUM_WIDTH); only DEPTH-1 is stored so 2**STATE_ADDR_WIDTH still fits.
    assign qbit_ext   = 32'(i_qbit_num);
    assign addr_bits  = qbit_ext - 32'(PE_NUM_WIDTH);
    assign cmd_bad    = (qbit_ext < 32'(PE_NUM_WIDTH)) || (addr_bits > 32'(STATE_ADDR_WIDTH));
    assign depth_full = DEPTH_ONE << addr_bits;
    assign depth_last = STATE_ADDR_WIDTH'(depth_full - DEPTH_ONE);
    assign ins_last   = ins_q - CTX_ONE;

    always_comb begin
        state_d  = state_q;
        qbit_d   = qbit_q;
        ins_d    = ins_q;
        ctx_k_d  = ctx_k_q;
        last_d   = last_q;
        addr_d   = addr_q;
        lat_d    = lat_q;
        cycles_d = cycles_q;
        rd_dat_d = rd_dat_q;
        err_d    = err_q;
`ifdef QEA_SEQ_TIMEOUT_EN
        tmo_d    = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_cmd_start) begin
                    if (cmd_bad) begin
                        err_d = 1'b1;
                    end else begin
                        err_d    = 1'b0;
                        cycles_d = '0;
                        qbit_d   = i_qbit_num;
                        ins_d    = i_ins_num;
                        last_d   = depth_last;
                        ctx_k_d  = '0;
                        addr_d   = '0;
                        state_d  = (i_ins_num == '0) ? S_INIT : S_CTX;
                    end
                end
            end
            S_CTX: begin
                if (i_ctx_valid) begin
                    if (ctx_k_q == ins_last) begin
                        state_d = S_INIT;
                    end else begin
                        ctx_k_d = ctx_k_q + CTX_ONE;
                    end
                end
            end
            S_INIT: begin
                if (addr_q == last_q) begin
                    state_d = S_START;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            S_START: begin
                cycles_d = CNT_ONE;
`ifdef QEA_SEQ_TIMEOUT_EN
                tmo_d    = '0;
`endif
                state_d  = S_RUN;
            end
            S_RUN: begin
                if (i_qea_complete) begin
                    addr_d  = '0;
                    state_d = S_RISSUE;
                end else begin
                    if (cycles_q != '1) begin
                        cycles_d = cycles_q + CNT_ONE;
                    end
`ifdef QEA_SEQ_TIMEOUT_EN
                    if (tmo_q == TMO_LAST) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        tmo_d = tmo_q + 32'd1;
                    end
`endif
                end
            end
            S_RISSUE: begin
                lat_d   = '0;
                state_d = S_RWAIT;
            end
            S_RWAIT: begin
                if (lat_q == LAT_LAST) begin
                    rd_dat_d = i_state_dout;
                    state_d  = S_ROUT;
                end else begin
                    lat_d = lat_q + LAT_ONE;
                end
            end
            S_ROUT: begin
                if (i_rd_ready) begin
                    if (addr_q == last_q) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + ADDR_ONE;
                        state_d = S_RISSUE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            qbit_q   <= '0;
            ins_q    <= '0;
            ctx_k_q  <= '0;
            last_q   <= '0;
            addr_q   <= '0;
            lat_q    <= '0;
            cycles_q <= '0;
            rd_dat_q <= '0;
            err_q    <= 1'b0;
`ifdef QEA_SEQ_TIMEOUT_EN
            tmo_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            qbit_q   <= qbit_d;
            ins_q    <= ins_d;
            ctx_k_q  <= ctx_k_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            lat_q    <= lat_d;
            cycles_q <= cycles_d;
            rd_dat_q <= rd_dat_d;
            err_q    <= err_d;
`ifdef QEA_SEQ_TIMEOUT_EN
            tmo_q    <= tmo_d;
`endif
        end
    end

    logic st_ctx, st_init, st_rissue;
    assign st_ctx    = (state_q == S_CTX);
    assign st_init   = (state_q == S_INIT);
    assign st_rissue = (state_q == S_RISSUE);

    // RAM strobes decode straight from state so an async reset kills them in the same instant.
    assign o_ctx_ready   = st_ctx;
    assign o_ctx_en      = st_ctx & i_ctx_valid;
    assign o_ctx_wea     = st_ctx & i_ctx_valid;
    assign o_ctx_addr    = st_ctx ? ctx_k_q : '0;
    assign o_ctx_data    = st_ctx ? i_ctx_data : '0;
    assign o_state_ena   = {PE_NUM{st_init | st_rissue}};
    assign o_state_wea   = {PE_NUM{st_init}};
    assign o_state_addra = (st_init | st_rissue) ? addr_q : '0;
    assign o_state_dina  = (st_init && (addr_q == '0)) ? INIT_WORD : '0;
    assign o_qea_start   = (state_q == S_START);
    assign o_qbit_num    = qbit_q;
    assign o_rd_valid    = (state_q == S_ROUT);
    assign o_rd_data     = rd_dat_q;
    assign o_busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign o_done        = (state_q == S_DONE);
    assign o_err         = err_q;
    assign o_cycles      = cycles_q;

endmodule
